mac_acc_22: RTL and testbench

Serial dot-product accumulator that feeds the 22-bit fixed-point divider in the GRU FP datapath. It accepts a frame of N_TERMS signed 8-bit operand pairs and accumulates their products into a saturating 22-bit signed sum. It captures a signed 8-bit scale at frame start, then presents the sum and scale as dividend/divisor with a level-held start. When the divider reports done, it issues a one-cycle clear so the divider can be re-armed.

---
 rtl/mac_acc_22.sv | 126 ++++++++++++
 tb/tb_mac_acc_22.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_acc_22.sv
// mac_acc_22: serial signed 8x8 dot-product accumulator with 22-bit
// saturating sum, handing dividend/divisor to a fixed-point divider.
//
// Ports:
//   clock, rst        rising-edge clock, synchronous active-high reset
//   start, scale      frame start (IDLE only) and signed divisor capture
//   in_valid,in_ready operand handshake (ready only while accumulating)
//   x, w              signed 8-bit operand pair
//   dividend,divisor  sum and captured scale, stable while div_start
//   div_start         level request, held until div_done is sampled
//   div_done          divider completion level
//   div_clear         one-cycle re-arm pulse after done
//   busy              any state other than IDLE
//   sat_flag          sticky per frame, accumulator clamped
//   zero_div          captured scale was 0 and replaced by 1
module mac_acc_22 #(
  parameter int unsigned N_TERMS = 16
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              start,
  input  logic signed [7:0] scale,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic signed [7:0] x,
  input  logic signed [7:0] w,
  output logic [21:0]       dividend,
  output logic [7:0]        divisor,
  output logic              div_start,
  input  logic              div_done,
  output logic              div_clear,
  output logic              busy,
  output logic              sat_flag,
  output logic              zero_div
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  localparam logic [7:0] LAST = 8'(N_TERMS - 1);

  localparam logic signed [22:0] MAX_S = 23'sd2097151;
  localparam logic signed [22:0] MIN_S = -23'sd2097152;

  logic [1:0]         state;
  logic signed [21:0] acc;
  logic [7:0]         cnt;
  logic [7:0]         div_q;
  logic               sat_q;
  logic               zdiv_q;

  logic signed [15:0] prod;
  logic signed [22:0] sum;
  logic signed [21:0] acc_nxt;
  logic               clamp;

  // Sum is one bit wider than the accumulator so overflow
  // is visible before clamping.
  always_comb begin
    prod    = x * w;
    sum     = {{7{prod[15]}}, prod} + {acc[21], acc};
    acc_nxt = sum[21:0];
    clamp   = 1'b0;
    if (sum > MAX_S) begin
      acc_nxt = MAX_S[21:0];
      clamp   = 1'b1;
    end else if (sum < MIN_S) begin
      acc_nxt = MIN_S[21:0];
      clamp   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state  <= S_IDLE;
      acc    <= '0;
      cnt    <= '0;
      div_q  <= '0;
      sat_q  <= 1'b0;
      zdiv_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc    <= '0;
            cnt    <= '0;
            sat_q  <= 1'b0;
            zdiv_q <= (scale == 8'sd0);
            div_q  <= (scale == 8'sd0) ? 8'd1 : scale;
            state  <= S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (in_valid) begin
            acc <= acc_nxt;
            cnt <= cnt + 8'd1;
            if (clamp)
              sat_q <= 1'b1;
            if (cnt == LAST)
              state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (div_done)
            state <= S_CLEAR;
        end
        S_CLEAR: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (state == S_ACCUM);
  assign div_start = (state == S_ISSUE);
  assign div_clear = (state == S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign dividend  = acc;
  assign divisor   = div_q;
  assign sat_flag  = sat_q;
  assign zero_div  = zdiv_q;

endmodule

// File: tb/tb_mac_acc_22.sv
// tb_mac_acc_22: scoreboard bench for mac_acc_22,
// one 4-term and one 160-term instance.
module tb_mac_acc_22;

  typedef struct {
    int dut;
    int dvd;
    int dvs;
    int sat;
    int zd;
  } exp_t;

  logic clock;
  logic rst [2];
  logic start [2];
  logic [7:0] scale [2];
  logic in_valid [2];
  logic in_ready [2];
  logic [7:0] x [2];
  logic [7:0] w [2];
  logic [21:0] dividend [2];
  logic [7:0] divisor [2];
  logic div_start [2];
  logic div_done [2];
  logic div_clear [2];
  logic busy [2];
  logic sat_flag [2];
  logic zero_div [2];

  int vectors;
  int miscompares;
  exp_t exp_q [$];
  int fx [256];
  int fw [256];
  logic prev_ds [2];
  logic [21:0] held_dvd [2];

  mac_acc_22 #(.N_TERMS(4)) u_a (
    .clock(clock), .rst(rst[0]), .start(start[0]),
    .scale(scale[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .x(x[0]), .w(w[0]),
    .dividend(dividend[0]), .divisor(divisor[0]),
    .div_start(div_start[0]), .div_done(div_done[0]),
    .div_clear(div_clear[0]), .busy(busy[0]),
    .sat_flag(sat_flag[0]), .zero_div(zero_div[0])
  );

  mac_acc_22 #(.N_TERMS(160)) u_b (
    .clock(clock), .rst(rst[1]), .start(start[1]),
    .scale(scale[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .x(x[1]), .w(w[1]),
    .dividend(dividend[1]), .divisor(divisor[1]),
    .div_start(div_start[1]), .div_done(div_done[1]),
    .div_clear(div_clear[1]), .busy(busy[1]),
    .sat_flag(sat_flag[1]), .zero_div(zero_div[1])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name,
                       input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: pops on each rising div_start, then
  // requires dividend to stay put while the request is held.
  always @(negedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst[d] && div_start[d] === 1'b1) begin
        if (!prev_ds[d]) begin
          if (exp_q.size() == 0) begin
            check("unexpected_issue", 1, 0);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("issue_dut", d, e.dut);
            check("dividend", int'($signed(dividend[d])), e.dvd);
            check("divisor", int'($signed(divisor[d])), e.dvs);
            check("sat_flag", int'(sat_flag[d]), e.sat);
            check("zero_div", int'(zero_div[d]), e.zd);
          end
        end else begin
          check("dividend_stable", int'($signed(dividend[d])),
                int'($signed(held_dvd[d])));
        end
      end
      prev_ds[d]  = (div_start[d] === 1'b1);
      held_dvd[d] = dividend[d];
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // Drives one frame of n pairs from fx/fw. bub: 0 none,
  // 1 every other beat, 2 random. Bubbles also pulse start.
  task automatic frame(input int d, input int sc, input int n,
                       input int bub, input int ddly);
    exp_t e;
    int acc;
    int s;
    int sat;
    acc = 0;
    sat = 0;
    start[d] = 1'b1;
    scale[d] = 8'(sc);
    tick();
    start[d] = 1'b0;
    check("busy_after_start", int'(busy[d]), 1);
    check("ready_after_start", int'(in_ready[d]), 1);
    for (int i = 0; i < n; i++) begin
      if ((bub == 1 && i % 2 == 1) ||
          (bub == 2 && $urandom_range(0, 2) == 0)) begin
        in_valid[d] = 1'b0;
        start[d]    = 1'b1;
        x[d]        = 8'($urandom);
        w[d]        = 8'($urandom);
        tick();
        start[d]    = 1'b0;
      end
      in_valid[d] = 1'b1;
      x[d] = 8'(fx[i]);
      w[d] = 8'(fw[i]);
      s = acc + fx[i] * fw[i];
      if (s > 2097151) begin
        acc = 2097151;
        sat = 1;
      end else if (s < -2097152) begin
        acc = -2097152;
        sat = 1;
      end else begin
        acc = s;
      end
      tick();
    end
    in_valid[d] = 1'b0;
    e.dut = d;
    e.dvd = acc;
    e.dvs = (sc == 0) ? 1 : sc;
    e.sat = sat;
    e.zd  = (sc == 0) ? 1 : 0;
    exp_q.push_back(e);
    check("issue_latency", int'(div_start[d]), 1);
    check("ready_in_issue", int'(in_ready[d]), 0);
    for (int i = 0; i < ddly; i++) begin
      start[d] = (i == 0);
      tick();
    end
    start[d] = 1'b0;
    check("held_before_done", int'(div_start[d]), 1);
    div_done[d] = 1'b1;
    tick();
    div_done[d] = 1'b0;
    check("start_drop", int'(div_start[d]), 0);
    check("clear_pulse", int'(div_clear[d]), 1);
    tick();
    check("clear_one_cycle", int'(div_clear[d]), 0);
    check("idle_after_clear", int'(busy[d]), 0);
  endtask

  task automatic check_reset(input int d);
    check("rst_in_ready", int'(in_ready[d]), 0);
    check("rst_dividend", int'(dividend[d]), 0);
    check("rst_divisor", int'(divisor[d]), 0);
    check("rst_div_start", int'(div_start[d]), 0);
    check("rst_div_clear", int'(div_clear[d]), 0);
    check("rst_busy", int'(busy[d]), 0);
    check("rst_sat_flag", int'(sat_flag[d]), 0);
    check("rst_zero_div", int'(zero_div[d]), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; start[d] = 1'b0; scale[d] = '0;
      in_valid[d] = 1'b0; x[d] = '0; w[d] = '0;
      div_done[d] = 1'b0; prev_ds[d] = 1'b0;
      held_dvd[d] = '0;
    end
    tick();
    tick();
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    check_reset(0);
    check_reset(1);

    for (int i = 0; i < 4; i++) begin fx[i] = 10; fw[i] = 20; end
    frame(0, 5, 4, 0, 2);

    for (int i = 0; i < 4; i++) begin fx[i] = -128; fw[i] = 127; end
    frame(0, 9, 4, 1, 3);

    for (int i = 0; i < 4; i++) begin
      fx[i] = $urandom_range(0, 255) - 128;
      fw[i] = $urandom_range(0, 255) - 128;
    end
    frame(0, 0, 4, 0, 7);

    div_done[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("idle_done_busy", int'(busy[0]), 0);
      check("idle_done_clear", int'(div_clear[0]), 0);
    end
    div_done[0] = 1'b0;

    start[0] = 1'b1;
    scale[0] = 8'd3;
    tick();
    start[0] = 1'b0;
    in_valid[0] = 1'b1;
    x[0] = 8'd7;
    w[0] = 8'd9;
    tick();
    tick();
    in_valid[0] = 1'b0;
    rst[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    check_reset(0);
    tick();
    check("no_clear_after_rst", int'(div_clear[0]), 0);
    for (int i = 0; i < 4; i++) begin fx[i] = 1; fw[i] = 1; end
    frame(0, 2, 4, 0, 1);

    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < 4; i++) begin
        fx[i] = $urandom_range(0, 255) - 128;
        fw[i] = $urandom_range(0, 255) - 128;
      end
      frame(0, $urandom_range(0, 255) - 128, 4, 2,
            $urandom_range(0, 5));
    end

    for (int i = 0; i < 160; i++) begin fx[i] = -128; fw[i] = -128; end
    frame(1, 3, 160, 0, 2);

    for (int i = 0; i < 160; i++) begin
      fx[i] = $urandom_range(0, 6) - 3;
      fw[i] = $urandom_range(0, 6) - 3;
    end
    frame(1, -7, 160, 2, 1);

    for (int i = 0; i < 160; i++) begin
      fx[i] = (i < 150) ? 127 : -128;
      fw[i] = (i < 150) ? 127 : 127;
    end
    frame(1, 100, 160, 0, 0);

    tick();
    check("queue_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
